// File: rtl/uart_pkg.sv
// Register map, bit positions and reset values shared by the UART RX controller and its bench.
package uart_pkg;

   localparam logic [3:0] OFF_CTRL = 4'h0;
   localparam logic [3:0] OFF_BAUD = 4'h4;
   localparam logic [3:0] OFF_STAT = 4'h8;
   localparam logic [3:0] OFF_DATA = 4'hC;

   localparam int CTRL_EN         = 0;
   localparam int CTRL_DATA9B     = 1;
   localparam int CTRL_RXNE_IE    = 2;
   localparam int CTRL_THR_IE     = 3;
   localparam int CTRL_TO_IE      = 4;
   localparam int CTRL_THR_LSB    = 8;
   localparam int CTRL_TOTIME_LSB = 16;

   localparam int STAT_RXNE      = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_THRF      = 2;
   localparam int STAT_TO        = 3;
   localparam int STAT_OVR       = 4;
   localparam int STAT_COUNT_LSB = 8;

   typedef struct packed {
      logic [7:0] totime;
      logic [3:0] thr;
      logic       to_ie;
      logic       thr_ie;
      logic       rxne_ie;
      logic       data9b;
      logic       en;
   } ctrl_t;

   localparam ctrl_t       CTRL_RST = '0;
   localparam logic [23:0] BAUD_RST = 24'd0;

   function automatic logic [31:0] ctrl_pack(input ctrl_t c);
      logic [31:0] w;
      w = '0;
      w[CTRL_EN]                  = c.en;
      w[CTRL_DATA9B]              = c.data9b;
      w[CTRL_RXNE_IE]             = c.rxne_ie;
      w[CTRL_THR_IE]              = c.thr_ie;
      w[CTRL_TO_IE]               = c.to_ie;
      w[CTRL_THR_LSB +: 4]        = c.thr;
      w[CTRL_TOTIME_LSB +: 8]     = c.totime;
      return w;
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// APB-style slave bus of the UART RX controller; zero-wait-state, read data valid in the access phase.
interface uart_rx_ctrl_if;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [3:0]  paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;

   modport master (output psel, penable, pwrite, paddr, pwdata,
                   input  prdata, pready);
   modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                   output prdata, pready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous RX FIFO with synchronous flush; head is combinational and reads 0 while empty.
// Push while full and pop while empty are ignored.
module uart_rx_fifo #(
   parameter int FIFO_DEPTH = 16,
   parameter int FIFO_AW    = 4,
   parameter int DW         = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic [DW-1:0]    push_dat,
   input  logic             pop,
   output logic [DW-1:0]    head,
   output logic [FIFO_AW:0] count,
   output logic             full,
   output logic             empty
);

   logic [DW-1:0]      mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic               push_ok, pop_ok;

   assign full    = (count == (FIFO_AW+1)'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// RX controller for one uart_rx: register file, RX FIFO, idle timeout and interrupt.
// `define UART_RX_CTRL_DMA_EN adds a dma_req/dma_ack pop path with combinational dma_rdata.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int FIFO_AW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   uart_rx_ctrl_if.slave bus,
   output logic          irq,
   output logic          rx_clr_n,
   output logic [23:0]   rx_ckdiv,
   output logic          rx_data9b,
   output logic [7:0]    rx_totime,
   input  logic          rf_write,
   input  logic [8:0]    rf_wbyte,
   output logic          rf_full
`ifdef UART_RX_CTRL_DMA_EN
   ,
   output logic          dma_req,
   input  logic          dma_ack,
   output logic [8:0]    dma_rdata
`endif
);

   ctrl_t            ctrl, ctrl_wr;
   logic [23:0]      ckdiv;
   logic             to_flag, ovr_flag;
   logic [23:0]      bit_cnt;
   logic [7:0]       idle_cnt;

   logic             access, wr, rd;
   logic [3:0]       offset;
   logic             wr_ctrl, wr_baud, wr_stat, rd_data, flush;

   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [8:0]       fifo_head, push_dat;
   logic [FIFO_AW:0] fifo_count;
   logic             rxne, thrf, tick, idle_clr, to_set;
   logic [31:0]      stat_word;
   logic             unused_bits;

   assign access  = bus.psel & bus.penable;
   assign wr      = access & bus.pwrite;
   assign rd      = access & ~bus.pwrite;
   assign offset  = {bus.paddr[3:2], 2'b00};
   assign wr_ctrl = wr & (offset == OFF_CTRL);
   assign wr_baud = wr & (offset == OFF_BAUD);
   assign wr_stat = wr & (offset == OFF_STAT);
   assign rd_data = rd & (offset == OFF_DATA);
   assign flush   = wr_ctrl & ctrl.en & ~bus.pwdata[CTRL_EN];
   assign bus.pready  = 1'b1;
   assign unused_bits = ^{bus.pwdata[31:24], bus.paddr[1:0]};

   // DATA9B may only change while the receiver is (or is being put) in clear.
   always_comb begin
      ctrl_wr         = '0;
      ctrl_wr.en      = bus.pwdata[CTRL_EN];
      ctrl_wr.data9b  = (ctrl.en & bus.pwdata[CTRL_EN]) ? ctrl.data9b : bus.pwdata[CTRL_DATA9B];
      ctrl_wr.rxne_ie = bus.pwdata[CTRL_RXNE_IE];
      ctrl_wr.thr_ie  = bus.pwdata[CTRL_THR_IE];
      ctrl_wr.to_ie   = bus.pwdata[CTRL_TO_IE];
      ctrl_wr.thr     = bus.pwdata[CTRL_THR_LSB +: 4];
      ctrl_wr.totime  = bus.pwdata[CTRL_TOTIME_LSB +: 8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl  <= CTRL_RST;
         ckdiv <= BAUD_RST;
      end else begin
         if (wr_ctrl)              ctrl  <= ctrl_wr;
         if (wr_baud && !ctrl.en)  ckdiv <= bus.pwdata[23:0];
      end
   end

   assign rx_clr_n  = ctrl.en;
   assign rx_ckdiv  = ckdiv;
   assign rx_data9b = ctrl.data9b;
   assign rx_totime = ctrl.totime;

   assign push_dat  = {rf_wbyte[8] & ctrl.data9b, rf_wbyte[7:0]};
   assign fifo_push = rf_write & ~fifo_full;
`ifdef UART_RX_CTRL_DMA_EN
   assign fifo_pop  = (rd_data | dma_ack) & ~fifo_empty;
   assign dma_rdata = fifo_head;
`else
   assign fifo_pop  = rd_data & ~fifo_empty;
`endif

   uart_rx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .FIFO_AW    (FIFO_AW),
      .DW         (9)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (flush),
      .push     (fifo_push),
      .push_dat (push_dat),
      .pop      (fifo_pop),
      .head     (fifo_head),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign rf_full = fifo_full;
   assign rxne    = ~fifo_empty;
   // An empty FIFO never meets the threshold, so THR=0 behaves like THR=1.
   assign thrf    = rxne & (32'(fifo_count) >= 32'(ctrl.thr));

   assign tick     = ctrl.en & (bit_cnt == '0);
   assign idle_clr = rf_write | fifo_pop | fifo_empty | flush;
   assign to_set   = tick & ~idle_clr & (ctrl.totime != 8'd0) &
                     (idle_cnt != 8'hFF) & ((idle_cnt + 8'd1) == ctrl.totime);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt  <= '0;
         idle_cnt <= '0;
      end else begin
         if (!ctrl.en || flush) bit_cnt <= '0;
         else if (tick)         bit_cnt <= ckdiv;
         else                   bit_cnt <= bit_cnt - 24'd1;

         if (idle_clr)                        idle_cnt <= '0;
         else if (tick && idle_cnt != 8'hFF)  idle_cnt <= idle_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_flag  <= 1'b0;
         ovr_flag <= 1'b0;
         irq      <= 1'b0;
      end else begin
         if (flush)                                to_flag <= 1'b0;
         else if (to_set)                          to_flag <= 1'b1;
         else if (wr_stat && bus.pwdata[STAT_TO])  to_flag <= 1'b0;

         if (rf_write && fifo_full)                 ovr_flag <= 1'b1;
         else if (wr_stat && bus.pwdata[STAT_OVR])  ovr_flag <= 1'b0;

         irq <= (rxne & ctrl.rxne_ie) | (thrf & ctrl.thr_ie) |
                (to_flag & ctrl.to_ie) | ovr_flag;
      end
   end

`ifdef UART_RX_CTRL_DMA_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dma_req <= 1'b0;
      else        dma_req <= ctrl.en & rxne & (thrf | to_flag);
   end
`endif

   always_comb begin
      stat_word                                 = '0;
      stat_word[STAT_RXNE]                      = rxne;
      stat_word[STAT_FULL]                      = fifo_full;
      stat_word[STAT_THRF]                      = thrf;
      stat_word[STAT_TO]                        = to_flag;
      stat_word[STAT_OVR]                       = ovr_flag;
      stat_word[STAT_COUNT_LSB +: FIFO_AW+1]    = fifo_count;
   end

   always_comb begin
      bus.prdata = '0;
      if (rd) begin
         case (offset)
            OFF_CTRL: bus.prdata = ctrl_pack(ctrl);
            OFF_BAUD: bus.prdata = {8'd0, ckdiv};
            OFF_STAT: bus.prdata = stat_word;
            OFF_DATA: bus.prdata = {23'd0, fifo_head};
            default:  bus.prdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus a randomized push/pop run against a queue model.
module tb_uart_rx_ctrl;
   import uart_pkg::*;

   localparam int DEPTH = 16;

   logic        clk, rst_n;
   logic        irq, rx_clr_n, rx_data9b, rf_write, rf_full;
   logic [23:0] rx_ckdiv;
   logic [7:0]  rx_totime;
   logic [8:0]  rf_wbyte;
`ifdef UART_RX_CTRL_DMA_EN
   logic        dma_req, dma_ack;
   logic [8:0]  dma_rdata;
`endif

   uart_rx_ctrl_if bus();

   uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .FIFO_AW(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .irq       (irq),
      .rx_clr_n  (rx_clr_n),
      .rx_ckdiv  (rx_ckdiv),
      .rx_data9b (rx_data9b),
      .rx_totime (rx_totime),
      .rf_write  (rf_write),
      .rf_wbyte  (rf_wbyte),
      .rf_full   (rf_full)
`ifdef UART_RX_CTRL_DMA_EN
      ,
      .dma_req   (dma_req),
      .dma_ack   (dma_ack),
      .dma_rdata (dma_rdata)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model
   logic [8:0] q[$];
   bit         m_ovr, m_to, m_9b, m_rxie, m_thrie, m_toie;
   int         m_thr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_stat();
      int c;
      logic [31:0] s;
      c = q.size();
      s = 32'(c) * 256;
      if (m_ovr) s += 16;
      if (m_to) s += 8;
      if (c > 0 && c >= m_thr) s += 4;
      if (c == DEPTH) s += 2;
      if (c > 0) s += 1;
      return s;
   endfunction

   function automatic logic exp_irq();
      int c;
      c = q.size();
      return (m_rxie && c > 0) || (m_thrie && c > 0 && c >= m_thr) || (m_toie && m_to) || m_ovr;
   endfunction

   function automatic void model_push(input logic [8:0] b, input bit was_full);
      if (was_full) m_ovr = 1'b1;
      else          q.push_back(m_9b ? b : {1'b0, b[7:0]});
   endfunction

   function automatic logic [31:0] model_pop();
      if (q.size() == 0) return 32'd0;
      return {23'd0, q.pop_front()};
   endfunction

   task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = a; bus.pwdata = d;
      @(posedge clk); #1;
      bus.penable = 1'b1;
      @(posedge clk); #1;
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
   endtask

   task automatic apb_read_push(input logic [3:0] a, input bit pe, input logic [8:0] pb,
                                output logic [31:0] d);
      @(posedge clk); #1;
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = a;
      @(posedge clk); #1;
      bus.penable = 1'b1; rf_write = pe; rf_wbyte = pb;
      #3 d = bus.prdata;
      @(posedge clk); #1;
      bus.psel = 1'b0; bus.penable = 1'b0; rf_write = 1'b0;
   endtask

   task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
      apb_read_push(a, 1'b0, 9'd0, d);
   endtask

   task automatic push(input logic [8:0] b);
      bit was_full;
      was_full = (q.size() == DEPTH);
      @(posedge clk); #1;
      rf_write = 1'b1; rf_wbyte = b;
      @(posedge clk); #1;
      rf_write = 1'b0;
      model_push(b, was_full);
   endtask

   task automatic wait_irq(input int limit, output int cyc);
      cyc = -1;
      for (int i = 1; i <= limit; i++) begin
         @(posedge clk); #1;
         if (irq) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic set_ctrl(input logic [31:0] v);
      apb_write(OFF_CTRL, v);
      if (!v[CTRL_EN]) begin
         q.delete();
         m_to = 1'b0;
      end
      m_9b = v[CTRL_DATA9B];
      m_rxie = v[CTRL_RXNE_IE];
      m_thrie = v[CTRL_THR_IE];
      m_toie = v[CTRL_TO_IE];
      m_thr = int'(v[11:8]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, e;
      int cyc;

      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
      rf_write = 1'b0; rf_wbyte = '0;
`ifdef UART_RX_CTRL_DMA_EN
      dma_ack = 1'b0;
`endif
      m_ovr = 0; m_to = 0; m_9b = 0; m_rxie = 0; m_thrie = 0; m_toie = 0; m_thr = 0;
      rst_n = 1'b0;
      #12;
      check("rst_irq", 32'(irq), 0);
      check("rst_rf_full", 32'(rf_full), 0);
      check("rst_pready", 32'(bus.pready), 1);
      #10 rst_n = 1'b1;
      #1;
      check("rst_clr_n", 32'(rx_clr_n), 0);
      check("rst_ckdiv", 32'(rx_ckdiv), 0);
      check("rst_data9b", 32'(rx_data9b), 0);
      check("rst_totime", 32'(rx_totime), 0);
      check("rst_prdata", bus.prdata, 0);
      apb_read(OFF_STAT, d); check("rst_stat", d, exp_stat());
      apb_read(OFF_CTRL, d); check("rst_ctrl", d, 0);

      // baseline receive
      apb_write(OFF_BAUD, 32'd3);
      set_ctrl(32'h1);
      check("base_clr_n", 32'(rx_clr_n), 1);
      check("base_ckdiv", 32'(rx_ckdiv), 3);
      push(9'h0A5);
      apb_read(OFF_STAT, d); check("base_stat1", d, 32'h105);
      // setup phase alone on DATA must neither drive prdata nor pop
      @(posedge clk); #1;
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = OFF_DATA;
      #2 check("setup_prdata", bus.prdata, 0);
      @(posedge clk); #1 bus.psel = 1'b0;
      apb_read(OFF_STAT, d); check("setup_nopop", d, exp_stat());
      apb_read(OFF_DATA, d); e = model_pop(); check("base_data", d, 32'h0A5);
      apb_read(OFF_STAT, d); check("base_stat0", d, 32'h0);

      // fill and overrun
      for (int i = 0; i < DEPTH; i++) push(9'(i));
      apb_read(OFF_STAT, d); check("fill_stat", d, exp_stat());
      check("fill_rf_full", 32'(rf_full), 1);
      push(9'h1FF);
      @(posedge clk); #1;
      check("ovr_irq", 32'(irq), 1);
      apb_read(OFF_STAT, d); check("ovr_stat", d, exp_stat());
      for (int i = 0; i < DEPTH; i++) begin
         apb_read(OFF_DATA, d); e = model_pop();
         check($sformatf("drain_%0d", i), d, 32'(i));
      end
      apb_write(OFF_STAT, 32'h10); m_ovr = 1'b0;
      apb_read(OFF_STAT, d); check("w1c_ovr_stat", d, exp_stat());
      check("w1c_ovr_irq", 32'(irq), 0);

      // idle timeout
      set_ctrl(32'h0003_0011);
      check("to_totime", 32'(rx_totime), 3);
      push(9'h055);
      wait_irq(40, cyc);
      check("to_latency", 32'(cyc >= 8 && cyc <= 17), 1);
      m_to = 1'b1;
      apb_read(OFF_STAT, d); check("to_stat", d, exp_stat());
      apb_write(OFF_STAT, 32'h8); m_to = 1'b0;
      apb_read(OFF_STAT, d); check("to_w1c", d, exp_stat());
      check("to_w1c_irq", 32'(irq), 0);
      apb_read(OFF_DATA, d); check("to_data", d, model_pop());

      // simultaneous push and pop, empty read
      set_ctrl(32'h1);
      push(9'h011);
      apb_read_push(OFF_DATA, 1'b1, 9'h022, d);
      e = model_pop(); model_push(9'h022, 1'b0);
      check("simul_data", d, e);
      apb_read(OFF_STAT, d); check("simul_stat", d, exp_stat());
      apb_read(OFF_DATA, d); check("simul_data2", d, model_pop());
      apb_read(OFF_DATA, d); check("empty_data", d, 0);
      apb_read(OFF_STAT, d); check("empty_stat", d, exp_stat());

      // config lock and flush
      apb_write(OFF_BAUD, 32'd7);
      apb_read(OFF_BAUD, d); check("lock_baud", d, 3);
      apb_write(OFF_CTRL, 32'h3);
      check("lock_data9b", 32'(rx_data9b), 0);
      set_ctrl(32'h0003_0011);
      for (int i = 0; i < 5; i++) push(9'h100 + 9'(i));
      wait_irq(40, cyc);
      check("flush_pre_to", 32'(irq), 1);
      m_to = 1'b1;
      apb_read(OFF_STAT, d); check("flush_pre_stat", d, exp_stat());
      set_ctrl(32'h0);
      apb_read(OFF_STAT, d); check("flush_stat", d, exp_stat());
      check("flush_clr_n", 32'(rx_clr_n), 0);
      check("flush_irq", 32'(irq), 0);
      apb_write(OFF_BAUD, 32'd7);
      apb_read(OFF_BAUD, d); check("unlock_baud", d, 7);
      check("unlock_ckdiv", 32'(rx_ckdiv), 7);
      set_ctrl(32'h1);
      set_ctrl(32'h2);
      check("unlock_data9b", 32'(rx_data9b), 1);

      // randomized run, timeout disabled by a very long bit period
      set_ctrl(32'h0);
      apb_write(OFF_BAUD, 32'h00FF_FFFF);
      begin
         logic [31:0] cfg;
         cfg = (32'($urandom_range(0, 1)) << 1) | (32'($urandom_range(0, 1)) << 2) |
               (32'($urandom_range(0, 1)) << 3) | (32'($urandom_range(1, 15)) << 8);
         set_ctrl(cfg);
         set_ctrl(cfg | 32'h1);
      end
      for (int it = 0; it < 250; it++) begin
         int op;
         logic [8:0] b;
         op = $urandom_range(0, 9);
         b = 9'($urandom);
         if (op <= 4) begin
            push(b);
         end else if (op <= 6) begin
            apb_read(OFF_DATA, d); check("rnd_data", d, model_pop());
         end else if (op == 7) begin
            apb_read(OFF_STAT, d); check("rnd_stat", d, exp_stat());
            check("rnd_irq", 32'(irq), 32'(exp_irq()));
         end else if (op == 8) begin
            apb_write(OFF_STAT, 32'h10); m_ovr = 1'b0;
         end else begin
            bit was_full;
            was_full = (q.size() == DEPTH);
            apb_read_push(OFF_DATA, 1'b1, b, d);
            e = model_pop(); model_push(b, was_full);
            check("rnd_simul", d, e);
         end
      end
      apb_read(OFF_STAT, d); check("rnd_final", d, exp_stat());

`ifdef UART_RX_CTRL_DMA_EN
      set_ctrl(32'h0);
      apb_write(OFF_STAT, 32'h18); m_ovr = 1'b0;
      set_ctrl(32'h0401);
      for (int i = 0; i < 4; i++) push(9'h0C0 + 9'(i));
      @(posedge clk); #1;
      check("dma_req_on", 32'(dma_req), 1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("dma_rdata_%0d", i), 32'(dma_rdata), 32'(q[0]));
         @(posedge clk); #1 dma_ack = 1'b1;
         @(posedge clk); #1 dma_ack = 1'b0;
         e = model_pop();
         if (i == 0) begin
            @(posedge clk); #1;
            check("dma_req_off", 32'(dma_req), 0);
         end
      end
      apb_read(OFF_STAT, d); check("dma_stat", d, exp_stat());
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Register-mapped controller for the UART receive datapath. It configures the receiver (enable/clear, baud divisor, 9-bit mode, timeout), buffers received characters in an RX FIFO, and drives the receiver's `rf_full` back-pressure. It also detects receive idle-timeout and raises a combined interrupt. It sits between a simple APB-style slave bus and one `uart_rx` instance.

Parameters:
- FIFO_DEPTH, 16, RX FIFO entries; power of two, minimum 2.
- FIFO_AW, 4, log2(FIFO_DEPTH).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- psel  in  1  bus select
- penable  in  1  access phase
- pwrite  in  1  1 = write
- paddr  in  4  byte address; [3:2] selects the register
- pwdata  in  32  write data
- prdata  out  32  read data, valid in the access phase
- pready  out  1  tied to 1 (zero wait states)
- irq  out  1  level interrupt
- rx_clr_n  out  1  to receiver `clr_n`
- rx_ckdiv  out  24  to receiver `ckdiv`
- rx_data9b  out  1  to receiver `data9b`
- rx_totime  out  8  to receiver `totime`
- rf_write  in  1  receiver push strobe
- rf_wbyte  in  9  receiver push data
- rf_full  out  1  to receiver; high when the FIFO is full

Behaviour:
- An access occurs when psel & penable; all effects happen on that clock edge. Idle and setup-phase cycles have no effect.
- CTRL (0x0), R/W, reset 0:
  - [0] EN, drives rx_clr_n
  - [1] DATA9B
  - [2] RXNE_IE
  - [3] THR_IE
  - [4] TO_IE
  - [11:8] THR, FIFO threshold
  - [23:16] TOTIME, in bit periods; 0 disables the timeout
- BAUD (0x4), R/W, reset 0: [23:0] CKDIV. Bit period = CKDIV+1 clk.
- Writes to BAUD and to CTRL.DATA9B are ignored while EN=1, unless the same CTRL write also clears EN.
- STAT (0x8), reset 0:
  - [0] RXNE (count≠0)
  - [1] FULL
  - [2] THRF (count≥THR)
  - [3] TO, sticky, write-1-clear
  - [4] OVR, sticky, write-1-clear
  - [12:8] COUNT
- DATA (0xC), read-only:
  - Returns {23'b0, head[8:0]} and pops one entry.
  - In 8-bit mode, bit 8 of an entry is 0.
  - Reading while empty returns 0, does not pop, and sets no flag.
- Unmapped or read-only writes are ignored. prdata is 0 outside read accesses.
- rx_clr_n, rx_ckdiv, rx_data9b and rx_totime come straight from registers: they reflect a write on the cycle after it.
- FIFO:
  - Push on rf_write when not full.
  - rf_write while full drops the data and sets OVR.
  - Push and pop in the same cycle: both happen and count is unchanged. At count=0 only the push happens.
  - rf_full = (count==FIFO_DEPTH), combinational from the count register.
- EN 1→0: FIFO flushed (count=0, pointers 0); TO and bit-tick counter cleared. OVR is retained.
- Timeout logic:
  - Bit-tick counter runs while EN: reloads with CKDIV and emits a tick at 0.
  - Idle counter: 8-bit, saturating, incremented per tick. Cleared by rf_write, by a DATA pop, and while the FIFO is empty.
  - TO is set on the cycle the idle counter reaches TOTIME, only if TOTIME≠0 and the FIFO is non-empty.
- irq = (RXNE&RXNE_IE) | (THRF&THR_IE) | (TO&TO_IE) | OVR. Registered: one cycle of latency from the flag.
- All outputs are 0 in reset, except pready=1.

Optional Feature:
UART_RX_CTRL_DMA_EN
- With the macro, add ports dma_req (out 1), dma_ack (in 1) and dma_rdata (out 9).
  - dma_req = EN & RXNE & (THRF | TO), registered.
  - dma_rdata = FIFO head, combinational.
  - A dma_ack pulse pops one entry. A DATA read and dma_ack in the same cycle pop only once; the bus read wins the data.
  - dma_ack while empty is ignored.
- Without the macro, none of these ports exist and the FIFO has only the bus pop path.

Decomposition:
- Package uart_pkg holds:
  - register offsets (CTRL, BAUD, STAT, DATA)
  - CTRL and STAT bit-position constants
  - the reset values
- One natural sub-module: uart_rx_fifo. A synchronous FIFO with push, pop, head data, count, full and empty, parameterised by FIFO_DEPTH and FIFO_AW.

Test Plan:
- Baseline receive: BAUD=3, CTRL=EN; one rf_write of 0x0A5 → STAT.RXNE=1 and COUNT=1; DATA read returns 0x000000A5; STAT then reads 0.
- Fill and overrun: 16 rf_writes of 0x00..0x0F → FULL=1 and rf_full=1. A 17th rf_write of 0x1FF → OVR=1 and irq=1, no data changes. 16 DATA reads return 0x00..0x0F in order. W1C of STAT[4] clears OVR and irq.
- Timeout: BAUD=3, TOTIME=3, TO_IE=1, one push, no reads → TO=1 at 12±4 clk after the push, irq high. Write STAT=0x8 → TO=0.
- Simultaneous events:
  - count=1, rf_write and DATA read in the same cycle → COUNT stays 1; read returns the old head.
  - Read while empty returns 0 and COUNT stays 0.
- Config lock and flush: with EN=1 write BAUD=7 → reads the old value. Load 5 entries, write CTRL=0 → COUNT=0, rx_clr_n=0, TO cleared; BAUD=7 is now accepted.
- DMA (macro on): THR=4, 4 pushes → dma_req=1. Four dma_ack pulses drain the FIFO, dma_rdata matches in order, and dma_req falls after the 1st ack (THRF clears at count 3).
